// File: rtl/l2_out_plane_arb_pkg.sv
// rtl/l2_out_plane_arb_pkg.sv - shared types and payload helpers for the L2 outgoing plane arbiter
//
// Purpose: coherence payload types, the plane source tag, the round-robin pointer
// encoding and helpers that build a zero-filled merged plane message per source.
package l2_out_plane_arb_pkg;

  localparam int COH_MSG_W   = 5;
  localparam int CACHE_ID_W  = 4;
  localparam int LINE_ADDR_W = 28;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = WORDS_PER_LINE * WORD_W;

  typedef logic [COH_MSG_W-1:0]      coh_msg_t;
  typedef logic [CACHE_ID_W-1:0]     cache_id_t;
  typedef logic [LINE_ADDR_W-1:0]    line_addr_t;
  typedef logic [LINE_W-1:0]         line_t;
  typedef logic [WORDS_PER_LINE-1:0] word_mask_t;

  // Source tag carried with every plane beat.
  typedef enum logic [1:0] {
    OUT_SRC_REQ = 2'd0,
    OUT_SRC_RSP = 2'd1,
    OUT_SRC_FWD = 2'd2
  } out_src_e;

  // Which of fwd/req is preferred on the next non-response grant.
  typedef enum logic {
    RR_REQ = 1'b0,
    RR_FWD = 1'b1
  } rr_ptr_e;

  // Merged plane payload; fields a source does not carry stay zero.
  typedef struct packed {
    coh_msg_t    coh_msg;
    cache_id_t   req_id;
    logic [1:0]  to_req;
    logic        hprot;
    line_addr_t  addr;
    line_t       line;
    word_mask_t  word_mask;
  } out_msg_t;

  function automatic out_msg_t pack_req(
    input coh_msg_t   coh_msg,
    input logic       hprot,
    input line_addr_t addr,
    input line_t      line,
    input word_mask_t word_mask
  );
    out_msg_t m;
    m           = '0;
    m.coh_msg   = coh_msg;
    m.hprot     = hprot;
    m.addr      = addr;
    m.line      = line;
    m.word_mask = word_mask;
    return m;
  endfunction

  // Used for both responses and forwards: identical field set, no hprot.
  function automatic out_msg_t pack_rsp(
    input coh_msg_t   coh_msg,
    input cache_id_t  req_id,
    input logic [1:0] to_req,
    input line_addr_t addr,
    input line_t      line,
    input word_mask_t word_mask
  );
    out_msg_t m;
    m           = '0;
    m.coh_msg   = coh_msg;
    m.req_id    = req_id;
    m.to_req    = to_req;
    m.addr      = addr;
    m.line      = line;
    m.word_mask = word_mask;
    return m;
  endfunction

endpackage

// File: rtl/l2_out_plane_arb_grant.sv
// rtl/l2_out_plane_arb_grant.sv - combinational grant and next-state logic for the plane arbiter
//
// Purpose: picks at most one source when the output stage can load, and
// computes the next round-robin pointer and response starvation count.
// Ports:
//   i_load                    output stage can accept a new message this cycle
//   i_req/rsp/fwd_valid       source valids
//   i_rr_ptr, i_starve_cnt    current arbiter state
//   o_gnt_req/rsp/fwd         one-hot (or zero) grant, already qualified by i_load
//   o_nxt_rr_ptr              pointer value for the next edge
//   o_nxt_starve_cnt          counter value for the next edge
module l2_out_plane_grant
  import l2_out_plane_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic             i_load,
  input  logic             i_req_valid,
  input  logic             i_rsp_valid,
  input  logic             i_fwd_valid,
  input  rr_ptr_e          i_rr_ptr,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_gnt_req,
  output logic             o_gnt_rsp,
  output logic             o_gnt_fwd,
  output rr_ptr_e          o_nxt_rr_ptr,
  output logic [CNT_W-1:0] o_nxt_starve_cnt
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic w_other_valid;
  logic w_under_lim;
  logic w_rsp_win;
  logic w_pick_fwd;

  always_comb begin
    w_other_valid    = i_fwd_valid | i_req_valid;
    w_under_lim      = (i_starve_cnt < STARVE_LIM);
    // Responses win unless they have already starved fwd/req for STARVE_MAX grants.
    w_rsp_win        = i_rsp_valid & (w_under_lim | ~w_other_valid);
    // Preferred side if it is valid, otherwise whichever of the two is.
    w_pick_fwd       = (i_rr_ptr == RR_FWD) ? i_fwd_valid : ~i_req_valid;

    o_gnt_req        = 1'b0;
    o_gnt_rsp        = 1'b0;
    o_gnt_fwd        = 1'b0;
    o_nxt_rr_ptr     = i_rr_ptr;
    o_nxt_starve_cnt = i_starve_cnt;

    if (i_load) begin
      if (w_rsp_win) begin
        o_gnt_rsp = 1'b1;
        // Only count grants that actually kept someone waiting.
        if (w_other_valid && w_under_lim) begin
          o_nxt_starve_cnt = i_starve_cnt + CNT_W'(1);
        end
      end else if (w_other_valid) begin
        o_nxt_starve_cnt = '0;
        if (w_pick_fwd) begin
          o_gnt_fwd    = 1'b1;
          o_nxt_rr_ptr = RR_REQ;
        end else begin
          o_gnt_req    = 1'b1;
          o_nxt_rr_ptr = RR_FWD;
        end
      end
    end
  end

endmodule

// File: rtl/l2_out_plane_arb.sv
// rtl/l2_out_plane_arb.sv - arbitrates L2 req/rsp/fwd outgoing channels onto one NoC plane
//
// Purpose: single registered output stage fed by a response-priority arbiter
// with a starvation bound and fwd/req round-robin; sustains one beat per cycle.
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-low reset
//   i_req_* / o_req_ready             request channel (coh_msg, hprot, addr, line, word_mask)
//   i_rsp_* / o_rsp_ready             response channel (coh_msg, req_id, to_req, addr, line, word_mask)
//   i_fwd_* / o_fwd_ready             forward channel (same fields as response)
//   o_out_valid, i_out_ready          plane handshake
//   o_out_src                         0=req, 1=rsp, 2=fwd
//   o_out_*                           merged payload, absent fields zero-filled
module l2_out_plane_arb
  import l2_out_plane_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,

  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [COH_MSG_W-1:0]      i_req_coh_msg,
  input  logic                      i_req_hprot,
  input  logic [LINE_ADDR_W-1:0]    i_req_addr,
  input  logic [LINE_W-1:0]         i_req_line,
  input  logic [WORDS_PER_LINE-1:0] i_req_word_mask,

  input  logic                      i_rsp_valid,
  output logic                      o_rsp_ready,
  input  logic [COH_MSG_W-1:0]      i_rsp_coh_msg,
  input  logic [CACHE_ID_W-1:0]     i_rsp_req_id,
  input  logic [1:0]                i_rsp_to_req,
  input  logic [LINE_ADDR_W-1:0]    i_rsp_addr,
  input  logic [LINE_W-1:0]         i_rsp_line,
  input  logic [WORDS_PER_LINE-1:0] i_rsp_word_mask,

  input  logic                      i_fwd_valid,
  output logic                      o_fwd_ready,
  input  logic [COH_MSG_W-1:0]      i_fwd_coh_msg,
  input  logic [CACHE_ID_W-1:0]     i_fwd_req_id,
  input  logic [1:0]                i_fwd_to_req,
  input  logic [LINE_ADDR_W-1:0]    i_fwd_addr,
  input  logic [LINE_W-1:0]         i_fwd_line,
  input  logic [WORDS_PER_LINE-1:0] i_fwd_word_mask,

  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [1:0]                o_out_src,
  output logic [COH_MSG_W-1:0]      o_out_coh_msg,
  output logic [CACHE_ID_W-1:0]     o_out_req_id,
  output logic [1:0]                o_out_to_req,
  output logic                      o_out_hprot,
  output logic [LINE_ADDR_W-1:0]    o_out_addr,
  output logic [LINE_W-1:0]         o_out_line,
  output logic [WORDS_PER_LINE-1:0] o_out_word_mask
);

  logic             r_out_valid;
  out_src_e         r_out_src;
  out_msg_t         r_msg;
  rr_ptr_e          r_rr_ptr;
  logic [CNT_W-1:0] r_starve_cnt;

  logic             w_load;
  logic             w_gnt_req;
  logic             w_gnt_rsp;
  logic             w_gnt_fwd;
  logic             w_any_gnt;
  rr_ptr_e          w_nxt_rr_ptr;
  logic [CNT_W-1:0] w_nxt_starve_cnt;
  out_msg_t         w_req_msg;
  out_msg_t         w_rsp_msg;
  out_msg_t         w_fwd_msg;
  out_msg_t         w_sel_msg;
  out_src_e         w_sel_src;

  // Empty stage, or its content leaves this cycle: a drain plus new grant is a
  // replace, so the plane sees no bubble.
  assign w_load = ~r_out_valid | i_out_ready;

  l2_out_plane_grant #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_grant (
    .i_load           (w_load),
    .i_req_valid      (i_req_valid),
    .i_rsp_valid      (i_rsp_valid),
    .i_fwd_valid      (i_fwd_valid),
    .i_rr_ptr         (r_rr_ptr),
    .i_starve_cnt     (r_starve_cnt),
    .o_gnt_req        (w_gnt_req),
    .o_gnt_rsp        (w_gnt_rsp),
    .o_gnt_fwd        (w_gnt_fwd),
    .o_nxt_rr_ptr     (w_nxt_rr_ptr),
    .o_nxt_starve_cnt (w_nxt_starve_cnt)
  );

  assign w_any_gnt   = w_gnt_req | w_gnt_rsp | w_gnt_fwd;
  assign o_req_ready = w_gnt_req;
  assign o_rsp_ready = w_gnt_rsp;
  assign o_fwd_ready = w_gnt_fwd;

  assign w_req_msg = pack_req(i_req_coh_msg, i_req_hprot, i_req_addr,
                              i_req_line, i_req_word_mask);
  assign w_rsp_msg = pack_rsp(i_rsp_coh_msg, i_rsp_req_id, i_rsp_to_req,
                              i_rsp_addr, i_rsp_line, i_rsp_word_mask);
  assign w_fwd_msg = pack_rsp(i_fwd_coh_msg, i_fwd_req_id, i_fwd_to_req,
                              i_fwd_addr, i_fwd_line, i_fwd_word_mask);

  always_comb begin
    w_sel_msg = r_msg;
    w_sel_src = r_out_src;
    if (w_gnt_rsp) begin
      w_sel_msg = w_rsp_msg;
      w_sel_src = OUT_SRC_RSP;
    end else if (w_gnt_fwd) begin
      w_sel_msg = w_fwd_msg;
      w_sel_src = OUT_SRC_FWD;
    end else if (w_gnt_req) begin
      w_sel_msg = w_req_msg;
      w_sel_src = OUT_SRC_REQ;
    end
  end

  // Arbiter state only advances when the stage loads, so a stalled plane
  // freezes both the output register and the fairness state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_out_valid  <= 1'b0;
      r_out_src    <= OUT_SRC_REQ;
      r_msg        <= '0;
      r_rr_ptr     <= RR_FWD;
      r_starve_cnt <= '0;
    end else if (w_load) begin
      r_out_valid  <= w_any_gnt;
      r_rr_ptr     <= w_nxt_rr_ptr;
      r_starve_cnt <= w_nxt_starve_cnt;
      if (w_any_gnt) begin
        r_msg     <= w_sel_msg;
        r_out_src <= w_sel_src;
      end
    end
  end

  assign o_out_valid     = r_out_valid;
  assign o_out_src       = r_out_src;
  assign o_out_coh_msg   = r_msg.coh_msg;
  assign o_out_req_id    = r_msg.req_id;
  assign o_out_to_req    = r_msg.to_req;
  assign o_out_hprot     = r_msg.hprot;
  assign o_out_addr      = r_msg.addr;
  assign o_out_line      = r_msg.line;
  assign o_out_word_mask = r_msg.word_mask;

endmodule

// File: tb/tb_l2_out_plane_arb.sv
// tb/tb_l2_out_plane_arb.sv - self-checking bench for the L2 outgoing plane arbiter
module tb_l2_out_plane_arb;
  import l2_out_plane_arb_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic out_ready = 1'b0;
  logic [2:0] src_valid = 3'b000;
  out_msg_t src_msg [3];

  logic o_req_ready, o_rsp_ready, o_fwd_ready, o_out_valid;
  logic [1:0] o_out_src;
  logic [COH_MSG_W-1:0] o_out_coh_msg;
  logic [CACHE_ID_W-1:0] o_out_req_id;
  logic [1:0] o_out_to_req;
  logic o_out_hprot;
  logic [LINE_ADDR_W-1:0] o_out_addr;
  logic [LINE_W-1:0] o_out_line;
  logic [WORDS_PER_LINE-1:0] o_out_word_mask;
  logic [2:0] rdy;
  out_msg_t obs_msg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rdy = {o_fwd_ready, o_rsp_ready, o_req_ready};
  assign obs_msg = {o_out_coh_msg, o_out_req_id, o_out_to_req, o_out_hprot,
                    o_out_addr, o_out_line, o_out_word_mask};

  l2_out_plane_arb #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(src_valid[0]), .o_req_ready(o_req_ready),
    .i_req_coh_msg(src_msg[0].coh_msg), .i_req_hprot(src_msg[0].hprot),
    .i_req_addr(src_msg[0].addr), .i_req_line(src_msg[0].line),
    .i_req_word_mask(src_msg[0].word_mask),
    .i_rsp_valid(src_valid[1]), .o_rsp_ready(o_rsp_ready),
    .i_rsp_coh_msg(src_msg[1].coh_msg), .i_rsp_req_id(src_msg[1].req_id),
    .i_rsp_to_req(src_msg[1].to_req), .i_rsp_addr(src_msg[1].addr),
    .i_rsp_line(src_msg[1].line), .i_rsp_word_mask(src_msg[1].word_mask),
    .i_fwd_valid(src_valid[2]), .o_fwd_ready(o_fwd_ready),
    .i_fwd_coh_msg(src_msg[2].coh_msg), .i_fwd_req_id(src_msg[2].req_id),
    .i_fwd_to_req(src_msg[2].to_req), .i_fwd_addr(src_msg[2].addr),
    .i_fwd_line(src_msg[2].line), .i_fwd_word_mask(src_msg[2].word_mask),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready), .o_out_src(o_out_src),
    .o_out_coh_msg(o_out_coh_msg), .o_out_req_id(o_out_req_id),
    .o_out_to_req(o_out_to_req), .o_out_hprot(o_out_hprot),
    .o_out_addr(o_out_addr), .o_out_line(o_out_line),
    .o_out_word_mask(o_out_word_mask)
  );

  function automatic out_msg_t rand_msg();
    out_msg_t m;
    m.coh_msg   = COH_MSG_W'($urandom);
    m.req_id    = CACHE_ID_W'($urandom);
    m.to_req    = 2'($urandom);
    m.hprot     = 1'($urandom);
    m.addr      = LINE_ADDR_W'($urandom);
    m.line      = {$urandom, $urandom, $urandom, $urandom};
    m.word_mask = WORDS_PER_LINE'($urandom);
    return m;
  endfunction

  // What the plane must carry for a message from source s.
  function automatic out_msg_t exp_fill(input int s, input out_msg_t m);
    out_msg_t r;
    r = m;
    if (s == 0) begin
      r.req_id = '0;
      r.to_req = '0;
    end else begin
      r.hprot = 1'b0;
    end
    return r;
  endfunction

  task automatic do_reset();
    src_valid = 3'b000;
    out_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) src_msg[s] = rand_msg();
    src_valid = 3'b000;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_out_valid !== 1'b0 || obs_msg !== '0 || o_out_src !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b src=%0d msg=%h, required valid=0 src=0 msg=0",
               o_out_valid, o_out_src, obs_msg);
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (o_out_valid !== 1'b0 || o_out_src !== 2'd0 || rdy !== 3'b000) begin
        failures++;
        $display("FAIL idle_cycle%0d: valid=%b src=%0d ready=%b, required 0 0 000",
                 i, o_out_valid, o_out_src, rdy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rsp_only();
    out_msg_t sent [3];
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        sent[k] = rand_msg();
        sent[k].addr = LINE_ADDR_W'(32'h10 + k);
        src_msg[1] = sent[k];
        src_valid[1] = 1'b1;
      end else begin
        src_valid[1] = 1'b0;
      end
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (rdy !== 3'b010) begin
          failures++;
          $display("FAIL rsp_only_ready%0d: ready=%b, required 010", k, rdy);
        end
      end
      if (k >= 1) begin
        checks++;
        if (o_out_valid !== 1'b1 || o_out_src !== 2'd1 || obs_msg !== exp_fill(1, sent[k-1])) begin
          failures++;
          $display("FAIL rsp_only_beat%0d: valid=%b src=%0d addr=%h, required 1 1 %h",
                   k - 1, o_out_valid, o_out_src, o_out_addr, 32'h10 + k - 1);
        end
      end
      checks++;
      if (dut.r_starve_cnt !== '0) begin
        failures++;
        $display("FAIL rsp_only_starve%0d: cnt=%0d, required 0", k, dut.r_starve_cnt);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_only_drain: valid=%b, required 0", o_out_valid);
    end
  endtask

  task automatic test_priority_pattern();
    int exp;
    do_reset();
    for (int s = 0; s < 3; s++) src_msg[s] = rand_msg();
    src_valid = 3'b111;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      // STARVE_MAX rsp beats then one fwd/req beat, fwd first after reset.
      if (i % (STARVE_MAX + 1) < STARVE_MAX) exp = 1;
      else exp = ((i / (STARVE_MAX + 1)) % 2 == 0) ? 2 : 0;
      checks++;
      if (o_out_valid !== 1'b1 || int'(o_out_src) != exp) begin
        failures++;
        $display("FAIL priority_beat%0d: valid=%b src=%0d, required 1 %0d",
                 i, o_out_valid, o_out_src, exp);
      end
    end
    @(posedge clk); #1 src_valid = 3'b000;
  endtask

  task automatic test_fwd_req_alt();
    int exp;
    do_reset();
    src_msg[0] = rand_msg();
    src_msg[0].hprot = 1'b1;
    src_msg[0].req_id = 4'hA;
    src_msg[2] = rand_msg();
    src_msg[2].hprot = 1'b1;
    src_msg[2].req_id = 4'h5;
    src_valid = 3'b101;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (i % 2 == 0) ? 2 : 0;
      checks++;
      if (int'(o_out_src) != exp || o_out_valid !== 1'b1) begin
        failures++;
        $display("FAIL alt_src%0d: src=%0d valid=%b, required %0d 1", i, o_out_src, o_out_valid, exp);
      end
      checks++;
      if (exp == 0 && (o_out_hprot !== 1'b1 || o_out_req_id !== '0 || o_out_to_req !== '0)) begin
        failures++;
        $display("FAIL alt_req_fields%0d: hprot=%b req_id=%0d to_req=%0d, required 1 0 0",
                 i, o_out_hprot, o_out_req_id, o_out_to_req);
      end else if (exp == 2 && (o_out_hprot !== 1'b0 || o_out_req_id !== 4'h5)) begin
        failures++;
        $display("FAIL alt_fwd_fields%0d: hprot=%b req_id=%0d, required 0 5",
                 i, o_out_hprot, o_out_req_id);
      end
    end
  endtask

  task automatic test_stall();
    out_msg_t a, b;
    do_reset();
    a = rand_msg();
    b = rand_msg();
    src_msg[1] = a;
    src_valid = 3'b010;
    out_ready = 1'b1;
    @(posedge clk); #1;
    src_msg[1] = b;
    src_msg[2] = rand_msg();
    src_valid = 3'b110;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_out_valid !== 1'b1 || o_out_src !== 2'd1 || obs_msg !== exp_fill(1, a) || rdy !== 3'b000) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b src=%0d ready=%b msg=%h, required 1 1 000 %h",
                 i, o_out_valid, o_out_src, rdy, obs_msg, exp_fill(1, a));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy !== 3'b010) begin
      failures++;
      $display("FAIL stall_release_ready: ready=%b, required 010", rdy);
    end
    @(posedge clk); #1 src_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (o_out_valid !== 1'b1 || obs_msg !== exp_fill(1, b)) begin
      failures++;
      $display("FAIL stall_no_bubble: valid=%b msg=%h, required 1 %h", o_out_valid, obs_msg, exp_fill(1, b));
    end
  endtask

  task automatic test_reset_mid();
    int exp;
    do_reset();
    src_msg[0] = rand_msg();
    src_msg[2] = rand_msg();
    src_valid = 3'b101;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (o_out_valid !== 1'b0 || obs_msg !== '0 || o_out_src !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_async: valid=%b src=%0d msg=%h, required 0 0 0", o_out_valid, o_out_src, obs_msg);
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (i == 0) ? 2 : 0;
      checks++;
      if (o_out_valid !== 1'b1 || int'(o_out_src) != exp) begin
        failures++;
        $display("FAIL reset_mid_order%0d: valid=%b src=%0d, required 1 %0d", i, o_out_valid, o_out_src, exp);
      end
    end
  endtask

  // Reference model: a response may go unless STARVE_MAX responses in a row
  // have already kept fwd/req waiting; otherwise fwd and req take turns.
  task automatic test_random();
    bit m_valid = 0;
    int m_src = 0;
    out_msg_t m_msg = '0;
    bit m_pref_fwd = 1;
    int m_streak = 0;
    int g;
    bit load;
    bit others;
    logic [2:0] exp_rdy;
    int rfail = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      load = !m_valid || out_ready;
      others = src_valid[0] || src_valid[2];
      g = -1;
      if (load) begin
        if (src_valid[1] && (m_streak < STARVE_MAX || !others)) g = 1;
        else if (others) g = m_pref_fwd ? (src_valid[2] ? 2 : 0) : (src_valid[0] ? 0 : 2);
      end
      exp_rdy = 3'b000;
      if (g >= 0) exp_rdy[g] = 1'b1;
      checks++;
      if (rdy !== exp_rdy) begin
        failures++; rfail++;
        if (rfail < 20) $display("FAIL rand_ready cyc%0d: ready=%b, required %b", cyc, rdy, exp_rdy);
      end
      checks++;
      if (o_out_valid !== m_valid || (m_valid && (int'(o_out_src) != m_src || obs_msg !== m_msg))) begin
        failures++; rfail++;
        if (rfail < 20) $display("FAIL rand_out cyc%0d: valid=%b src=%0d msg=%h, required %b %0d %h",
                                 cyc, o_out_valid, o_out_src, obs_msg, m_valid, m_src, m_msg);
      end
      @(posedge clk);
      if (load) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_src = g;
          m_msg = exp_fill(g, src_msg[g]);
        end
        if (g == 1 && others) m_streak++;
        if (g == 0 || g == 2) begin
          m_streak = 0;
          m_pref_fwd = (g == 0);
        end
      end
      #1;
      for (int s = 0; s < 3; s++) begin
        if (src_valid[s] && g == s) begin
          src_valid[s] = ($urandom_range(0, 3) != 0);
          src_msg[s] = rand_msg();
        end else if (!src_valid[s] && $urandom_range(0, 1) == 1) begin
          src_valid[s] = 1'b1;
          src_msg[s] = rand_msg();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rsp_only();
    test_priority_pattern();
    test_fwd_req_alt();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
